// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: streaming Avalon-ST HSV to RGB converter, 3-stage global-enable pipeline
module hsv_to_rgb (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop
);
  localparam logic [1:0] WAIT_SOP = 2'd0;
  localparam logic [1:0] VIDEO    = 2'd1;
  localparam logic [1:0] CONTROL  = 2'd2;
  logic [1:0]  state;
  logic        en, acc, conv0;
  logic [10:0] h6;
  logic        v1, v2, c1, c2, sop1, sop2, eop1, eop2;
  logic [23:0] d1, d2, rgb;
  logic [2:0]  sec1, sec2;
  logic [7:0]  f1, sf2, sg2, s, v, p, q, t;
  function automatic logic [7:0] mul_hi(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] m;
    m = {8'd0, a} * {8'd0, b};
    return m[15:8];
  endfunction
  assign en = !source_valid || source_ready;
  assign sink_ready = en;
  assign acc = sink_valid && en;
  assign conv0 = !sink_sop && state == VIDEO;
  assign h6 = {3'd0, sink_data[23:16]} * 11'd6;
  // packet classification: sop picks the packet type, eop always closes the packet
  always_ff @(posedge clk)
    if (reset) state <= WAIT_SOP;
    else if (acc) state <= sink_eop ? WAIT_SOP : sink_sop ? (sink_data[3:0] == 4'd0 ? VIDEO : CONTROL) : state;
  // stage valids advance together; a bubble enters when nothing is accepted
  always_ff @(posedge clk)
    if (reset) {v1, v2, source_valid} <= '0;
    else if (en) {v1, v2, source_valid} <= {acc, v1, v2};
  // stage 1: keep the raw beat and split h6 into sector and fraction
  always_ff @(posedge clk)
    if (en) begin
      d1   <= sink_data;
      c1   <= conv0;
      sop1 <= sink_sop;
      eop1 <= sink_eop;
      sec1 <= h6[10:8];
      f1   <= h6[7:0];
    end
  // stage 2: saturation-scaled fraction products used by q and t
  always_ff @(posedge clk)
    if (en) begin
      d2   <= d1;
      c2   <= c1;
      sop2 <= sop1;
      eop2 <= eop1;
      sec2 <= sec1;
      sf2  <= mul_hi(d1[15:8], f1);
      sg2  <= mul_hi(d1[15:8], 8'd255 - f1);
    end
  // stage 3 arithmetic: p/q/t and sector selection; grey when unsaturated
  always_comb begin
    s   = d2[15:8];
    v   = d2[7:0];
    p   = mul_hi(v, 8'd255 - s);
    q   = mul_hi(v, 8'd255 - sf2);
    t   = mul_hi(v, 8'd255 - sg2);
    rgb = s == 8'd0     ? {v, v, v} :
          sec2 == 3'd0  ? {v, t, p} :
          sec2 == 3'd1  ? {q, v, p} :
          sec2 == 3'd2  ? {p, v, t} :
          sec2 == 3'd3  ? {p, q, v} :
          sec2 == 3'd4  ? {t, p, v} : {v, p, q};
  end
  // stage 3 output register; only real beats overwrite it so data holds across bubbles and stalls
  always_ff @(posedge clk)
    if (reset) {source_data, source_sop, source_eop} <= '0;
    else if (en && v2) {source_data, source_sop, source_eop} <= {c2 ? rgb : d2, sop2, eop2};
endmodule
